muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for HI/LO-writing arithmetic: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- Sits in EX beside the ALU. It accepts the decoded op and operands, stalls the pipeline while it works, then returns a 64-bit HI/LO result with a whilo write strobe.
- Contains a pipelined multiplier path and an iterative radix-2 restoring divider. It supports cancellation by exception flush.

---
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- multi-cycle HI/LO arithmetic sequencer that sits in EX beside the ALU.
// It handles MULT/MULTU, DIV/DIVU and MADD(U)/MSUB(U). A pipelined multiplier and an
// iterative radix-2 restoring divider produce a 64-bit {HI,LO} result.
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   start_i    EX holds a muldiv op (held until done_o)
//   op_i       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   src_a_i    rs value
//   src_b_i    rt value
//   hilo_i     current {HI,LO} (forwarded), sampled at accept for accumulate ops
//   flush_i    exception/ERET flush, cancels any op
//   stall_o    freeze IF..EX
//   busy_o     sequencer not idle
//   done_o     one-cycle result-valid pulse
//   whilo_o    2'b11 on done (write HI and LO), else 0
//   hi_o/lo_o  last result, held until the next completion
module muldiv_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic [63:0] hilo_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_ACC, S_DIV_INIT, S_DIV_ITER, S_DIV_FIX, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] hilo_q;
  logic [63:0] pipe_q [MUL_LAT];
  logic [MCW-1:0] mul_cnt_q;
  logic [5:0]  div_cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        qneg_q, rneg_q;
  logic [63:0] result_q;

  // Op decode of the latched instruction
  logic q_div, q_acc, q_sub, q_signed, in_div, accept;
  assign q_div    = (op_q[2:1] == 2'b01);
  assign q_acc    = op_q[2];
  assign q_sub    = op_q[2] & op_q[1];
  assign q_signed = ~op_q[0];
  assign in_div   = (op_i[2:1] == 2'b01);
  assign accept   = (state_q == S_IDLE) & start_i & ~flush_i;

  // First multiplier stage works on the live operands in the accept cycle;
  // 33-bit signed operands cover both sign- and zero-extension.
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_full;
  assign mul_a    = {~op_i[0] & src_a_i[31], src_a_i};
  assign mul_b    = {~op_i[0] & src_b_i[31], src_b_i};
  assign mul_full = mul_a * mul_b;

  logic [63:0] product;
  logic        mul_last, div_last;
  assign product  = pipe_q[MUL_LAT-1];
  assign mul_last = (mul_cnt_q == MCW'(MUL_LAT - 1));
  assign div_last = (div_cnt_q == 6'(DIV_ITERS - 1));

  // Divider datapath
  logic [31:0] abs_a, abs_b, rem_n, quo_n, q_fix, r_fix;
  logic [32:0] shifted, diff;
  logic        ge;
  assign abs_a   = (q_signed & a_q[31]) ? -a_q : a_q;
  assign abs_b   = (q_signed & b_q[31]) ? -b_q : b_q;
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[32];
  assign rem_n   = ge ? diff[31:0] : shifted[31:0];
  assign quo_n   = {quo_q[30:0], ge};
  assign q_fix   = qneg_q ? -quo_q : quo_q;
  assign r_fix   = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start_i) state_d = in_div ? S_DIV_INIT : S_MUL;
        S_MUL:      if (mul_last) state_d = q_acc ? S_ACC : S_DONE;
        S_ACC:      state_d = S_DONE;
        S_DIV_INIT: state_d = (b_q == 32'd0) ? S_DONE : S_DIV_ITER;
        S_DIV_ITER: if (div_last) state_d = S_DIV_FIX;
        S_DIV_FIX:  state_d = S_DONE;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Multiplier pipeline: stage 0 loads at accept, later stages shift during MUL.
  // Stage 0 is held while busy, so every stage converges on the product.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (!resetn) begin
          pipe_q[gi] <= 64'd0;
        end else if (gi == 0) begin
          if (accept) pipe_q[gi] <= mul_full;
        end else if (state_q == S_MUL) begin
          pipe_q[gi] <= pipe_q[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      hilo_q    <= 64'd0;
      mul_cnt_q <= '0;
      div_cnt_q <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      if (accept) begin
        op_q      <= op_i;
        a_q       <= src_a_i;
        b_q       <= src_b_i;
        hilo_q    <= hilo_i;
        mul_cnt_q <= '0;
      end
      case (state_q)
        S_MUL: begin
          mul_cnt_q <= mul_cnt_q + MCW'(1);
          if (mul_last && !q_acc && !flush_i) result_q <= product;
        end
        S_ACC: begin
          if (!flush_i) result_q <= q_sub ? hilo_q - product : hilo_q + product;
        end
        S_DIV_INIT: begin
          rem_q     <= 32'd0;
          quo_q     <= abs_a;
          dvs_q     <= abs_b;
          qneg_q    <= q_signed & (a_q[31] ^ b_q[31]);
          rneg_q    <= q_signed & a_q[31];
          div_cnt_q <= 6'd0;
          // Divide-by-zero resolves here with a fixed result
          if (b_q == 32'd0 && q_div && !flush_i) result_q <= {a_q, 32'hFFFF_FFFF};
        end
        S_DIV_ITER: begin
          rem_q     <= rem_n;
          quo_q     <= quo_n;
          div_cnt_q <= div_cnt_q + 6'd1;
        end
        S_DIV_FIX: begin
          if (!flush_i) result_q <= {r_fix, q_fix};
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE) & ~flush_i;
  assign whilo_o = {2{done_o}};
  // Dropped in DONE so EX advances together with the HI/LO write
  assign stall_o = accept | (busy_o & (state_q != S_DONE));
  assign hi_o    = result_q[63:32];
  assign lo_o    = result_q[31:0];

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl. A cycle-level reference model
// (latency table plus plain 64-bit arithmetic) predicts every output on every cycle.
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk, resetn, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic [63:0] hilo_i;
  logic        stall_o, busy_o, done_o;
  logic [1:0]  whilo_o;
  logic [31:0] hi_o, lo_o;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .hilo_i(hilo_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  bit chk_en = 0;
  bit exp_busy, exp_stall, exp_done;
  logic [63:0] exp_res, prev_res;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Reference result from plain arithmetic
  function automatic logic [63:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [63:0] hl);
    longint sa, sb, p, q, r;
    sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    if (op == 3'd2 || op == 3'd3) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    p = sa * sb;
    if (op >= 3'd6) return hl - 64'(p);
    if (op >= 3'd4) return hl + 64'(p);
    return 64'(p);
  endfunction

  function automatic int ref_lat(logic [2:0] op, logic [31:0] b);
    if (op == 3'd2 || op == 3'd3) return (b == 32'd0) ? 2 : 35;
    if (op >= 3'd4) return MUL_LAT + 2;
    return MUL_LAT + 1;
  endfunction

  // Per-cycle comparison against the model's expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  64'(busy_o),  64'(exp_busy));
      chk("stall", 64'(stall_o), 64'(exp_stall));
      chk("done",  64'(done_o),  64'(exp_done));
      chk("whilo", 64'(whilo_o), exp_done ? 64'd3 : 64'd0);
      chk("hi",    64'(hi_o),    64'(exp_res[63:32]));
      chk("lo",    64'(lo_o),    64'(exp_res[31:0]));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction from accept (cycle 0) to its idle follow-up cycle.
  // flush_at / reset_at < 0 disables that abort.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hl, input int flush_at, input int reset_at,
                        input bit has_lit, input logic [63:0] lit);
    int lat;
    logic [63:0] res;
    bit did_reset, did_flush;
    lat = ref_lat(op, b);
    res = ref_result(op, a, b, hl);
    did_reset = 0;
    did_flush = 0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        next_cycle();
        op_i    = 3'($urandom);
        src_a_i = $urandom;
        src_b_i = $urandom;
        hilo_i  = {$urandom, $urandom};
      end else begin
        op_i = op; src_a_i = a; src_b_i = b; hilo_i = hl;
      end
      start_i   = 1'b1;
      flush_i   = (k == flush_at);
      resetn    = (k != reset_at);
      exp_busy  = (k >= 1);
      exp_stall = (k == 0) ? !flush_i : (k < lat);
      exp_done  = (k == lat);
      exp_res   = (k == lat) ? res : prev_res;
      if (k == flush_at || k == reset_at) begin
        exp_done  = 0;
        exp_res   = prev_res;
        did_reset = (k == reset_at);
        did_flush = (k == flush_at);
        break;
      end
      if (k == lat) begin
        prev_res = res;
        if (has_lit) chk("literal_hilo", {hi_o, lo_o}, lit);
      end
    end
    next_cycle();
    if (did_reset) prev_res = 64'd0;
    resetn = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    exp_busy = 0; exp_stall = 0; exp_done = 0; exp_res = prev_res;
    $display("txn op=%0d a=%h b=%h hilo=%h lat=%0d flush=%0d reset=%0d result=%h",
             op, a, b, hl, lat, did_flush, did_reset, res);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn = 0; start_i = 0; flush_i = 0; op_i = 0;
    src_a_i = 0; src_b_i = 0; hilo_i = 0;
    prev_res = 0; exp_res = 0; exp_busy = 0; exp_stall = 0; exp_done = 0;
    next_cycle();
    chk_en = 1;              // reset state checked while resetn is still low
    next_cycle();
    resetn = 1;
    next_cycle();

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, -1, -1, 1, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 64'd0, -1, -1, 1, 64'h0000_0002_FFFF_FFFA);
    run_op(3'd4, 32'd4, 32'd5, 64'h10, -1, -1, 1, 64'h24);
    run_op(3'd7, 32'd1, 32'd1, 64'd0, -1, -1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, -1, -1, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, -1, -1, 1, 64'h8000_0000_0000_0000);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, -1, -1, 1, 64'h0000_0000_8000_0000);
    run_op(3'd2, 32'd123, 32'd0, 64'd0, -1, -1, 1, 64'h0000_007B_FFFF_FFFF);
    // Flushed divide, then a MULT issued right after
    run_op(3'd2, 32'd100, 32'd7, 64'd0, 10, -1, 0, 64'd0);
    run_op(3'd0, 32'd6, 32'd7, 64'd0, -1, -1, 1, 64'd42);
    // Back-to-back: start in the idle cycle after DONE is a new instruction
    run_op(3'd1, 32'd9, 32'd9, 64'd0, -1, -1, 1, 64'd81);
    // Resets in the middle of operations
    run_op(3'd4, 32'd3, 32'd3, 64'd1, -1, 2, 0, 64'd0);
    run_op(3'd3, 32'd50, 32'd5, 64'd0, -1, 5, 0, 64'd0);
    next_cycle();

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] hl;
      int lat, fa, ra;
      op = 3'($urandom_range(0, 7));
      a = rnd32();
      b = rnd32();
      hl = {rnd32(), rnd32()};
      lat = ref_lat(op, b);
      fa = -1;
      ra = -1;
      if ($urandom_range(0, 7) == 0) fa = $urandom_range(0, lat - 1);
      else if ($urandom_range(0, 19) == 0) ra = $urandom_range(1, lat - 1);
      run_op(op, a, b, hl, fa, ra, 0, 64'd0);
      if ($urandom_range(0, 1) == 1) next_cycle();
    end

    next_cycle();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
